// File: rtl/pwm_pkg.sv
// PWM timebase shared definitions.
// Mode encodings, FSM state type and mode decode helper.
package pwm_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_UPDN = 2'b10;

  typedef enum logic [1:0] {
    ST_UP,
    ST_DOWN,
    ST_HALT
  } state_t;

  // The reserved encoding 11 behaves as plain up-counting.
  function automatic logic [1:0] mode_decode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_UP : m;
  endfunction

endpackage

// File: rtl/pwm_timebase_if.sv
// PWM timebase control/status bundle.
// master drives configuration, slave is the timebase.
interface pwm_timebase_if #(
  parameter int WIDTH   = 16,
  parameter int PSC_W   = 16,
  parameter int NUM_CMP = 2
) ();

  logic                     en;
  logic                     count_reset;
  logic [1:0]               mode;
  logic                     one_shot;
  logic [WIDTH-1:0]         period;
  logic [PSC_W-1:0]         prescale;
  logic [NUM_CMP*WIDTH-1:0] cmp_val;
  logic [WIDTH-1:0]         count_val;
  logic                     dir;
  logic                     running;
  logic                     tick;
  logic                     ovf;
  logic                     unf;
  logic [NUM_CMP-1:0]       cmp_match;

  modport master (
    output en, count_reset, mode, one_shot,
    output period, prescale, cmp_val,
    input  count_val, dir, running,
    input  tick, ovf, unf, cmp_match
  );

  modport slave (
    input  en, count_reset, mode, one_shot,
    input  period, prescale, cmp_val,
    output count_val, dir, running,
    output tick, ovf, unf, cmp_match
  );

endinterface

// File: rtl/pwm_prescaler.sv
// Linear prescaler: one step every top+1 enabled cycles.
// Counter is held at zero while cleared or disabled.
module pwm_prescaler #(
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [PSC_W-1:0] top,
  output logic             step
);

  localparam logic [PSC_W-1:0] ONE = 1;

  logic [PSC_W-1:0] cnt_q;
  logic             hit;

  assign hit  = (cnt_q == top);
  assign step = en && !clr && hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || !en || hit) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + ONE;
    end
  end

endmodule

// File: rtl/pwm_timebase.sv
// PWM timebase: up/down/centre counter with shadowed config,
// one-shot, event pulses and compare strobes.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int PSC_W   = 16,
  parameter int NUM_CMP = 2
) (
  input logic           clk,
  input logic           rst_n,
  pwm_timebase_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = 1;

  logic               en_q;
  logic [WIDTH-1:0]   period_a;
  logic [PSC_W-1:0]   prescale_a;
  logic [1:0]         mode_a;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               dir_q, dir_d;
  state_t             state_q, state_d;
  logic               run_d, running;
  logic               tick_q, tick_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [NUM_CMP-1:0] cmp_q, cmp_d;

  logic               en_rise, load_ext, step, upd;
  logic [1:0]         in_mode, cur_mode;
  logic [WIDTH-1:0]   cur_period;
  logic [PSC_W-1:0]   cur_psc;

  assign en_rise  = bus.en && !en_q;
  assign load_ext = bus.count_reset || en_rise;
  assign in_mode  = mode_decode(bus.mode);
  assign running  = (state_q != ST_HALT);

  // A load on this very cycle (enable edge) already governs this step.
  assign cur_mode   = load_ext ? in_mode : mode_a;
  assign cur_period = load_ext ? bus.period : period_a;
  assign cur_psc    = load_ext ? bus.prescale : prescale_a;

  pwm_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.count_reset),
    .en    (bus.en && running),
    .top   (cur_psc),
    .step  (step)
  );

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    run_d   = running;
    tick_d  = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    upd     = 1'b0;
    if (bus.count_reset) begin
      count_d = '0;
      dir_d   = (in_mode != MODE_DOWN);
      run_d   = 1'b1;
    end else if (bus.en) begin
      if (en_rise) begin
        dir_d = (in_mode != MODE_DOWN);
        run_d = 1'b1;
      end
      if (step) begin
        tick_d = 1'b1;
        unique case (1'b1)
          (cur_mode == MODE_DOWN): begin
            if (count_q == '0) begin
              count_d = cur_period;
              unf_d   = 1'b1;
              upd     = 1'b1;
            end else begin
              count_d = count_q - ONE;
            end
          end
          (cur_mode == MODE_UPDN): begin
            if (cur_period == '0) begin
              count_d = '0;
              ovf_d   = 1'b1;
              unf_d   = 1'b1;
              upd     = 1'b1;
              dir_d   = 1'b1;
            end else if (dir_d) begin
              if (count_q == cur_period) begin
                dir_d   = 1'b0;
                count_d = count_q - ONE;
                ovf_d   = 1'b1;
              end else begin
                count_d = count_q + ONE;
              end
            end else if (count_q == '0) begin
              dir_d   = 1'b1;
              count_d = count_q + ONE;
              unf_d   = 1'b1;
              upd     = 1'b1;
            end else begin
              count_d = count_q - ONE;
            end
          end
          default: begin
            if (count_q == cur_period) begin
              count_d = '0;
              ovf_d   = 1'b1;
              upd     = 1'b1;
            end else begin
              count_d = count_q + ONE;
            end
          end
        endcase
      end
      if (upd) begin
        dir_d = (in_mode != MODE_DOWN);
        if (bus.one_shot) begin
          run_d = 1'b0;
        end
      end
    end
    if (!run_d) begin
      state_d = ST_HALT;
    end else if (dir_d) begin
      state_d = ST_UP;
    end else begin
      state_d = ST_DOWN;
    end
  end

  for (genvar i = 0; i < NUM_CMP; i++) begin : g_cmp
    assign cmp_d[i] = tick_d &&
      (count_d == bus.cmp_val[i*WIDTH +: WIDTH]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      period_a   <= '0;
      prescale_a <= '0;
      mode_a     <= MODE_UP;
      count_q    <= '0;
      dir_q      <= 1'b1;
      state_q    <= ST_UP;
      tick_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      cmp_q      <= '0;
    end else begin
      en_q    <= bus.en;
      count_q <= count_d;
      dir_q   <= dir_d;
      state_q <= state_d;
      tick_q  <= tick_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      cmp_q   <= cmp_d;
      if (load_ext || upd) begin
        period_a   <= bus.period;
        prescale_a <= bus.prescale;
        mode_a     <= in_mode;
      end
    end
  end

  assign bus.count_val = count_q;
  assign bus.dir       = dir_q;
  assign bus.running   = running;
  assign bus.tick      = tick_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
  assign bus.cmp_match = cmp_q;

endmodule

// File: tb/tb_pwm_timebase.sv
// Scoreboard bench for pwm_timebase: directed vectors queue
// expected tick responses, a monitor pops them on every tick.
module tb_pwm_timebase;

  typedef struct {
    logic [15:0] cnt;
    logic        dir;
    logic        run;
    logic        ovf;
    logic        unf;
    logic [1:0]  cmp;
    int          gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_tick = 0;
  int   tick_no = 0;
  exp_t q[$];

  pwm_timebase_if #(.WIDTH(16), .PSC_W(16), .NUM_CMP(2)) bus ();

  pwm_timebase #(.WIDTH(16), .PSC_W(16), .NUM_CMP(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic d, input logic r,
                      input logic o, input logic u,
                      input logic [1:0] m, input int g);
    exp_t e;
    e.cnt = 16'(c);
    e.dir = d;
    e.run = r;
    e.ovf = o;
    e.unf = u;
    e.cmp = m;
    e.gap = g;
    q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic restart(input logic [1:0] m, input int p,
                         input int psc, input logic os);
    @(negedge clk);
    bus.mode        = m;
    bus.period      = 16'(p);
    bus.prescale    = 16'(psc);
    bus.one_shot    = os;
    bus.en          = 1'b1;
    bus.count_reset = 1'b1;
    @(negedge clk);
    bus.count_reset = 1'b0;
  endtask

  task automatic run_stop(input int n);
    repeat (n) @(negedge clk);
    bus.en = 1'b0;
  endtask

  // Monitor: one comparison per tick, stray pulses flagged otherwise.
  initial begin
    exp_t e;
    int   g;
    forever begin
      @(negedge clk);
      if (rst_n && bus.tick) begin
        n_cmp++;
        tick_no++;
        g = cyc - last_tick;
        last_tick = cyc;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_tick #%0d: got cnt=%0d, want no tick",
                   tick_no, bus.count_val);
        end else begin
          e = q.pop_front();
          if (bus.count_val !== e.cnt || bus.dir !== e.dir ||
              bus.running !== e.run || bus.ovf !== e.ovf ||
              bus.unf !== e.unf || bus.cmp_match !== e.cmp ||
              (e.gap != 0 && g != e.gap)) begin
            n_err++;
            $display({"FAIL tick #%0d: got cnt=%0d dir=%0b run=%0b ",
                      "ovf=%0b unf=%0b cmp=%b gap=%0d, want cnt=%0d ",
                      "dir=%0b run=%0b ovf=%0b unf=%0b cmp=%b gap=%0d"},
                     tick_no, bus.count_val, bus.dir, bus.running,
                     bus.ovf, bus.unf, bus.cmp_match, g, e.cnt, e.dir,
                     e.run, e.ovf, e.unf, e.cmp, e.gap);
          end
        end
      end else if (rst_n) begin
        n_cmp++;
        if (bus.ovf || bus.unf || bus.cmp_match != 2'b00) begin
          n_err++;
          $display("FAIL stray_pulse: got ovf=%0b unf=%0b cmp=%b, want 0",
                   bus.ovf, bus.unf, bus.cmp_match);
        end
      end
    end
  end

  initial begin
    bus.en          = 1'b0;
    bus.count_reset = 1'b0;
    bus.mode        = 2'b00;
    bus.one_shot    = 1'b0;
    bus.period      = '0;
    bus.prescale    = '0;
    bus.cmp_val     = {16'd100, 16'd200};

    repeat (2) @(negedge clk);
    check("rst_count", int'(bus.count_val), 0);
    check("rst_dir", int'(bus.dir), 1);
    check("rst_running", int'(bus.running), 1);
    check("rst_tick", int'(bus.tick), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    check("rst_unf", int'(bus.unf), 0);
    check("rst_cmp", int'(bus.cmp_match), 0);
    rst_n = 1'b1;

    // One-shot down from reset, then restart by en toggle.
    @(negedge clk);
    bus.mode     = 2'b01;
    bus.period   = 16'd2;
    bus.one_shot = 1'b1;
    bus.en       = 1'b1;
    push(2, 0, 0, 0, 1, 2'b00, 0);
    repeat (4) @(negedge clk);
    check("os_running", int'(bus.running), 0);
    check("os_hold", int'(bus.count_val), 2);
    check("os_dir", int'(bus.dir), 0);
    push(1, 0, 1, 0, 0, 2'b00, 0);
    push(0, 0, 1, 0, 0, 2'b00, 1);
    push(2, 0, 0, 0, 1, 2'b00, 1);
    bus.en = 1'b0;
    @(negedge clk);
    bus.en = 1'b1;
    @(negedge clk);
    check("os_rearm", int'(bus.running), 1);
    run_stop(6);
    check("os_halt_again", int'(bus.running), 0);
    bus.one_shot = 1'b0;

    // Up, period 4, channel 0 at 1, channel 1 at 3.
    bus.cmp_val = {16'd3, 16'd1};
    push(1, 1, 1, 0, 0, 2'b01, 0);
    push(2, 1, 1, 0, 0, 2'b00, 1);
    push(3, 1, 1, 0, 0, 2'b10, 1);
    push(4, 1, 1, 0, 0, 2'b00, 1);
    push(0, 1, 1, 1, 0, 2'b00, 1);
    restart(2'b00, 4, 0, 1'b0);
    run_stop(5);

    // Up with prescale 2; period 10 -> 3 applied after the wrap.
    bus.cmp_val = {16'd100, 16'd200};
    for (int i = 1; i <= 10; i++) push(i, 1, 1, 0, 0, 2'b00, (i == 1) ? 0 : 3);
    push(0, 1, 1, 1, 0, 2'b00, 3);
    for (int i = 1; i <= 3; i++) push(i, 1, 1, 0, 0, 2'b00, 3);
    push(0, 1, 1, 1, 0, 2'b00, 3);
    restart(2'b00, 10, 2, 1'b0);
    repeat (18) @(negedge clk);
    bus.period = 16'd3;
    run_stop(28);

    // Centre-aligned, period 3.
    push(1, 1, 1, 0, 0, 2'b00, 0);
    push(2, 1, 1, 0, 0, 2'b00, 1);
    push(3, 1, 1, 0, 0, 2'b00, 1);
    push(2, 0, 1, 1, 0, 2'b00, 1);
    push(1, 0, 1, 0, 0, 2'b00, 1);
    push(0, 0, 1, 0, 0, 2'b00, 1);
    push(1, 1, 1, 0, 1, 2'b00, 1);
    restart(2'b10, 3, 0, 1'b0);
    run_stop(7);

    // Reserved mode 11 counts up.
    push(1, 1, 1, 0, 0, 2'b00, 0);
    push(0, 1, 1, 1, 0, 2'b00, 1);
    restart(2'b11, 1, 0, 1'b0);
    run_stop(2);

    // Equal compare values on both channels, up period 5.
    bus.cmp_val = {16'd2, 16'd2};
    push(1, 1, 1, 0, 0, 2'b00, 0);
    push(2, 1, 1, 0, 0, 2'b11, 1);
    push(3, 1, 1, 0, 0, 2'b00, 1);
    push(4, 1, 1, 0, 0, 2'b00, 1);
    push(5, 1, 1, 0, 0, 2'b00, 1);
    push(0, 1, 1, 1, 0, 2'b00, 1);
    push(1, 1, 1, 0, 0, 2'b00, 1);
    push(2, 1, 1, 0, 0, 2'b11, 1);
    restart(2'b00, 5, 0, 1'b0);
    run_stop(8);

    // count_reset beats the wrap step, then async reset mid-run.
    bus.cmp_val = {16'd100, 16'd200};
    push(1, 1, 1, 0, 0, 2'b00, 0);
    push(2, 1, 1, 0, 0, 2'b00, 1);
    push(3, 1, 1, 0, 0, 2'b00, 1);
    restart(2'b00, 3, 0, 1'b0);
    repeat (3) @(negedge clk);
    bus.count_reset = 1'b1;
    @(negedge clk);
    bus.count_reset = 1'b0;
    check("crst_count", int'(bus.count_val), 0);
    check("crst_ovf", int'(bus.ovf), 0);
    check("crst_tick", int'(bus.tick), 0);
    push(1, 1, 1, 0, 0, 2'b00, 0);
    push(2, 1, 1, 0, 0, 2'b00, 1);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", int'(bus.count_val), 0);
    check("arst_dir", int'(bus.dir), 1);
    check("arst_running", int'(bus.running), 1);
    check("arst_tick", int'(bus.tick), 0);
    bus.en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
